// File: rtl/ula_pkg.sv
// Shared types and constants for the sequential ALU front-end.
// The parent decodes op codes in the ALU; this block only passes them through.
package ula_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    EXEC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_SHR = 2'd2;
  localparam logic [1:0] OP_SHL = 2'd3;

  localparam logic [7:0] CNT_MAX = 8'hFF;

endpackage

// File: rtl/sat_counter.sv
// 8-bit event counter that sticks at its maximum; clr wins over inc.
module sat_counter
  import ula_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  // count register: clear first, then saturating increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 8'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Sequencer that collects two operands and an op code, presents them to an
// external ALU, registers its result and holds it until the consumer takes it.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       op_in,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] input_a,
  output logic [WIDTH-1:0] input_b,
  input  logic [WIDTH-1:0] output_s,
  input  logic             ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result_q,
  output logic             ovf_q,
  output logic [7:0]       ovf_count
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic             cap_a;
  logic             cap_b;
  logic             do_exec;

  // state register; clear aborts to IDLE from anywhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state and capture strobes
  always_comb begin
    state_next = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    do_exec    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = GET_A;
        else       state_next = IDLE;
      end
      GET_A: begin
        if (in_valid) begin
          cap_a      = 1'b1;
          state_next = GET_B;
        end else begin
          state_next = GET_A;
        end
      end
      GET_B: begin
        if (in_valid) begin
          cap_b      = 1'b1;
          state_next = EXEC;
        end else begin
          state_next = GET_B;
        end
      end
      EXEC: begin
        do_exec    = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (res_ready) state_next = IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // operand and result registers; an abort leaves them untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= {WIDTH{1'b0}};
      b_reg    <= {WIDTH{1'b0}};
      op_reg   <= 2'd0;
      result_q <= {WIDTH{1'b0}};
      ovf_q    <= 1'b0;
    end else if (!clear) begin
      if (cap_a) begin
        a_reg  <= data_in;
        op_reg <= op_in;
      end
      if (cap_b) begin
        b_reg <= data_in;
      end
      if (do_exec) begin
        result_q <= output_s;
        ovf_q    <= ovf;
      end
    end
  end

  assign in_ready  = (state == GET_A) || (state == GET_B);
  assign res_valid = (state == DONE);
  assign sel       = op_reg;
  assign input_a   = a_reg;
  assign input_b   = b_reg;

  sat_counter u_ovf_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (do_exec && ovf),
    .count (ovf_count)
  );

endmodule

// File: tb/tb_ula_seq.sv
// Bench for ula_seq: behavioural ALU and protocol model checked every cycle,
// directed vectors with literal expectations, then randomized traffic.
module tb_ula_seq;
  import ula_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_in;
  logic [1:0]   op_in;
  logic [1:0]   sel;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic [W-1:0] output_s;
  logic         ovf;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result_q;
  logic         ovf_q;
  logic [7:0]   ovf_count;
  logic [W:0]   alu_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .op_in     (op_in),
    .sel       (sel),
    .input_a   (input_a),
    .input_b   (input_b),
    .output_s  (output_s),
    .ovf       (ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result_q  (result_q),
    .ovf_q     (ovf_q),
    .ovf_count (ovf_count)
  );

  // Reference ALU: {ovf, result}; shifts flag any bit shifted out.
  function automatic logic [W:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wide;
    case (op)
      OP_ADD: return {1'b0, a} + {1'b0, b};
      OP_SUB: return {(a < b), a - b};
      OP_SHR: begin
        wide = {a, {W{1'b0}}} >> b;
        return {|wide[W-1:0], wide[2*W-1:W]};
      end
      default: begin
        wide = {{W{1'b0}}, a} << b;
        return {|wide[2*W-1:W], wide[W-1:0]};
      end
    endcase
  endfunction

  always_comb alu_out = alu_fn(sel, input_a, input_b);
  assign output_s = alu_out[W-1:0];
  assign ovf      = alu_out[W];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which phase of an operation we are in, plus held values.
  localparam int P_IDLE = 0, P_WAIT_A = 1, P_WAIT_B = 2, P_COMPUTE = 3, P_HOLD = 4;
  int           m_ph;
  logic [W-1:0] m_a, m_b, m_res;
  logic [1:0]   m_op;
  logic         m_ovf;
  int           m_cnt;

  initial begin
    logic [W:0] r;
    m_ph = P_IDLE; m_a = '0; m_b = '0; m_op = 2'd0; m_res = '0; m_ovf = 1'b0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ph = P_IDLE; m_a = '0; m_b = '0; m_op = 2'd0; m_res = '0; m_ovf = 1'b0; m_cnt = 0;
      end
      chk("m_in_ready",  32'(in_ready),  32'(m_ph == P_WAIT_A || m_ph == P_WAIT_B));
      chk("m_res_valid", 32'(res_valid), 32'(m_ph == P_HOLD));
      chk("m_sel",       32'(sel),       32'(m_op));
      chk("m_input_a",   32'(input_a),   32'(m_a));
      chk("m_input_b",   32'(input_b),   32'(m_b));
      chk("m_result_q",  32'(result_q),  32'(m_res));
      chk("m_ovf_q",     32'(ovf_q),     32'(m_ovf));
      chk("m_ovf_count", 32'(ovf_count), 32'(m_cnt));
      if (rst_n) begin
        if (clear) begin
          m_ph = P_IDLE;
          m_cnt = 0;
        end else begin
          case (m_ph)
            P_IDLE:   if (start) m_ph = P_WAIT_A;
            P_WAIT_A: if (in_valid) begin m_a = data_in; m_op = op_in; m_ph = P_WAIT_B; end
            P_WAIT_B: if (in_valid) begin m_b = data_in; m_ph = P_COMPUTE; end
            P_COMPUTE: begin
              r = alu_fn(m_op, m_a, m_b);
              m_res = r[W-1:0];
              m_ovf = r[W];
              if (m_ovf && m_cnt < 255) m_cnt = m_cnt + 1;
              m_ph = P_HOLD;
            end
            default:  if (res_ready) m_ph = P_IDLE;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs start/A/B; returns cycles from the B-accept cycle to res_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [1:0] op, input logic [W-1:0] b, output int lat);
    int n;
    start = 1'b1; in_valid = 1'b1; data_in = ~a; op_in = ~op;
    tick();
    start = 1'b0; in_valid = 1'b1; data_in = a; op_in = op;
    tick();
    data_in = b; op_in = ~op;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    lat = n + 1;
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; in_valid = 1'b0;
    data_in = '0; op_in = 2'd0; res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_sel",       32'(sel),       32'd0);
    chk("rst_input_a",   32'(input_a),   32'd0);
    chk("rst_input_b",   32'(input_b),   32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;
    tick();

    do_op(4'd7, OP_ADD, 4'd9, lat);
    chk("add_latency", 32'(lat), 32'd2);
    chk("add_result",  32'(result_q), 32'h0);
    chk("add_ovf",     32'(ovf_q), 32'd1);
    chk("add_count",   32'(ovf_count), 32'd1);
    take_result();

    do_op(4'd3, OP_SUB, 4'd5, lat);
    chk("sub_result", 32'(result_q), 32'hE);
    chk("sub_ovf",    32'(ovf_q), 32'd1);
    chk("sub_count",  32'(ovf_count), 32'd2);
    take_result();

    do_op(4'd8, OP_SHR, 4'd2, lat);
    chk("shr_result", 32'(result_q), 32'h2);
    chk("shr_ovf",    32'(ovf_q), 32'd0);
    take_result();

    do_op(4'd9, OP_SHL, 4'd1, lat);
    chk("shl_result", 32'(result_q), 32'h2);
    chk("shl_ovf",    32'(ovf_q), 32'd1);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; in_valid = 1'b1; data_in = W'($urandom); op_in = 2'($urandom);
      tick();
      chk("hold_valid",    32'(res_valid), 32'd1);
      chk("hold_result",   32'(result_q),  32'h2);
      chk("hold_ovf",      32'(ovf_q),     32'd1);
      chk("hold_in_ready", 32'(in_ready),  32'd0);
    end
    start = 1'b0; in_valid = 1'b0;
    take_result();

    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; data_in = 4'd5; op_in = OP_SUB;
    tick();
    clear = 1'b1; start = 1'b1; res_ready = 1'b1; data_in = 4'd6;
    tick();
    clear = 1'b0; start = 1'b0; res_ready = 1'b0; in_valid = 1'b0;
    chk("clr_in_ready",  32'(in_ready),  32'd0);
    chk("clr_count",     32'(ovf_count), 32'd0);
    chk("clr_res_valid", 32'(res_valid), 32'd0);
    chk("clr_keep_a",    32'(input_a),   32'd5);
    chk("clr_keep_b",    32'(input_b),   32'd1);
    repeat (3) tick();
    chk("clr_no_valid", 32'(res_valid), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; data_in = 4'd4; op_in = OP_SHL;
    tick();
    data_in = 4'd3;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  32'(in_ready),  32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_sel",       32'(sel),       32'd0);
    chk("arst_input_a",   32'(input_a),   32'd0);
    chk("arst_input_b",   32'(input_b),   32'd0);
    chk("arst_result",    32'(result_q),  32'd0);
    chk("arst_ovf_q",     32'(ovf_q),     32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    do_op(4'd7, OP_ADD, 4'd9, lat);
    chk("post_rst_latency", 32'(lat), 32'd2);
    chk("post_rst_result",  32'(result_q), 32'h0);
    chk("post_rst_count",   32'(ovf_count), 32'd1);
    take_result();

    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 255; i++) begin
      do_op(4'd7, OP_ADD, 4'd9, lat);
      take_result();
    end
    chk("sat_255", 32'(ovf_count), 32'd255);
    do_op(4'd7, OP_ADD, 4'd9, lat);
    take_result();
    chk("sat_hold", 32'(ovf_count), 32'd255);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 99) < 35);
      in_valid  = ($urandom_range(0, 99) < 50);
      res_ready = ($urandom_range(0, 99) < 35);
      clear     = ($urandom_range(0, 99) < 3);
      data_in   = W'($urandom);
      op_in     = 2'($urandom);
      tick();
    end
    start = 1'b0; in_valid = 1'b0; res_ready = 1'b0; clear = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand/result width; must match the downstream ALU.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clear  input  1  synchronous abort and counter clear, active-high.
REQ-005 start  input  1  begin a new operation; sampled in IDLE only.
REQ-006 in_valid  input  1  data_in/op_in valid.
REQ-007 in_ready  output  1  block accepts data_in/op_in this cycle.
REQ-008 data_in  input  WIDTH  operand A, then operand B.
REQ-009 op_in  input  2  operation code, captured with operand A.
REQ-010 sel  output  2  op code to ALU.
REQ-011 input_a  output  WIDTH  operand A to ALU.
REQ-012 input_b  output  WIDTH  operand B to ALU.
REQ-013 output_s  input  WIDTH  ALU result.
REQ-014 ovf  input  1  ALU carry/borrow/shift-out bit.
REQ-015 res_valid  output  1  result_q/ovf_q hold a completed result.
REQ-016 res_ready  input  1  consumer takes the result.
REQ-017 result_q  output  WIDTH  registered ALU result.
REQ-018 ovf_q  output  1  registered ALU ovf.
REQ-019 ovf_count  output  8  count of completed operations with ovf=1.

Function
REQ-020 FSM states SHALL be IDLE, GET_A, GET_B, EXEC, DONE.
REQ-021 IDLE: start=1 -> GET_A next cycle; in_valid ignored; in_ready=0.
REQ-022 GET_A: in_ready=1; on in_valid: a_reg<=data_in, op_reg<=op_in, -> GET_B.
REQ-023 GET_B: in_ready=1; on in_valid: b_reg<=data_in, -> EXEC; op_in ignored.
REQ-024 in_ready SHALL be 1 only in GET_A/GET_B, driven combinationally from state.
REQ-025 sel, input_a, input_b SHALL be driven directly from op_reg, a_reg, b_reg at all times.
REQ-026 EXEC lasts exactly one cycle: result_q<=output_s, ovf_q<=ovf, -> DONE.
REQ-027 EXEC with ovf=1: ovf_count increments by 1, saturating at 255.
REQ-028 DONE: res_valid=1; result_q/ovf_q stable; on res_ready -> IDLE.
REQ-029 start asserted in any state other than IDLE SHALL be ignored.
REQ-030 Latency: last operand accept to res_valid = 2 cycles; start to res_valid minimum 4 cycles.
REQ-031 clear=1 (any state): FSM -> IDLE, ovf_count<=0, res_valid deasserts next cycle; a_reg/b_reg/op_reg/result_q/ovf_q keep values; clear has priority over start, in_valid and res_ready.
REQ-032 Op codes: 0 add, 1 sub, 2 shift right, 3 shift left; no decoding in this block beyond pass-through.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE and all registers to 0: a_reg, b_reg, op_reg, result_q, ovf_q, ovf_count.
REQ-034 During and right after reset: in_ready=0, res_valid=0, sel=0, input_a=0, input_b=0.
REQ-035 Reset mid-operation SHALL discard partial operands; no result is produced.

Structure
REQ-036 Package ula_pkg SHALL hold the state enum and the op-code constants (OP_ADD, OP_SUB, OP_SHR, OP_SHL).
REQ-037 ula_seq SHALL not instantiate the ALU; the parent connects sel/input_a/input_b/output_s/ovf.
REQ-038 One sub-module is natural: sat_counter (8-bit saturating counter with inc and clr).

Verification (WIDTH=4, ALU connected)
REQ-039 start; A=7 op=0; B=9 -> result_q=0, ovf_q=1, ovf_count=1, res_valid 2 cycles after B accept.
REQ-040 A=3 op=1; B=5 -> result_q=4'hE, ovf_q=1; A=8 op=2; B=2 -> result_q=2, ovf_q=0.
REQ-041 A=9 op=3; B=1 -> result_q=2, ovf_q=1; hold res_ready=0 for 5 cycles -> outputs stable, start ignored.
REQ-042 clear asserted in GET_B -> IDLE next cycle, ovf_count=0, in_ready=0, no res_valid.
REQ-043 rst_n pulsed low in EXEC -> all outputs 0 immediately; new start then works normally.
REQ-044 256 overflowing ops (7+9) -> ovf_count saturates at 255.
